// File: rtl/cpu_axi_bridge.sv
// CPU valid/ready memory port to AXI4-Lite master bridge, one transaction in flight, with watchdog.
// Optional macro CPU_AXI_BRIDGE_WAIT_BRESP_EN: wait for the B channel before completing writes.
module cpu_axi_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        CLK,
    input  logic        RSTb,

    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,

    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,

    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,

    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready,

    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,

    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,
    input  logic [31:0] mem_axi_rdata,

    output logic        bus_error
);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StWrResp,
        StDone
    } state_e;

    localparam bit          WdogEn   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] WdogLast = WdogEn ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_e      state_q, state_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] araddr_q, araddr_d;
    logic [2:0]  arprot_q, arprot_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [2:0]  awprot_q, awprot_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_ready_q, mem_ready_d;
    logic        bus_error_q, bus_error_d;
    logic [15:0] wdog_q, wdog_d;

    logic        timeout;
    logic        aw_hs, w_hs;
    logic        aw_all, w_all;

`ifdef CPU_AXI_BRIDGE_WAIT_BRESP_EN
    logic        bready_q, bready_d;
`else
    logic        unused_bvalid;
    assign unused_bvalid = mem_axi_bvalid;
`endif

    assign timeout = WdogEn && (wdog_q == WdogLast);
    assign aw_hs   = awvalid_q & mem_axi_awready;
    assign w_hs    = wvalid_q & mem_axi_wready;
    assign aw_all  = aw_done_q | aw_hs;
    assign w_all   = w_done_q | w_hs;

    always_comb begin
        state_d     = state_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        araddr_d    = araddr_q;
        arprot_d    = arprot_q;
        awaddr_d    = awaddr_q;
        awprot_d    = awprot_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        mem_ready_d = 1'b0;
        bus_error_d = bus_error_q;
        wdog_d      = wdog_q;
`ifdef CPU_AXI_BRIDGE_WAIT_BRESP_EN
        bready_d    = bready_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (mem_valid) begin
                    wdog_d = 16'd0;
                    if (mem_wstrb == 4'd0) begin
                        araddr_d  = mem_addr;
                        arprot_d  = {mem_instr, 2'b00};
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        state_d   = StRd;
                    end else begin
                        awaddr_d  = mem_addr;
                        awprot_d  = 3'b000;
                        wdata_d   = mem_wdata;
                        wstrb_d   = mem_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = StWr;
                    end
                end
            end

            StRd: begin
                wdog_d = wdog_q + 16'd1;
                if (arvalid_q && mem_axi_arready) begin
                    arvalid_d = 1'b0;
                end
                // A response in the timeout cycle still completes normally.
                if (mem_axi_rvalid && rready_q) begin
                    rdata_d     = mem_axi_rdata;
                    arvalid_d   = 1'b0;
                    rready_d    = 1'b0;
                    mem_ready_d = 1'b1;
                    state_d     = StDone;
                end else if (timeout) begin
                    rdata_d     = ERR_DATA;
                    arvalid_d   = 1'b0;
                    rready_d    = 1'b0;
                    bus_error_d = 1'b1;
                    mem_ready_d = 1'b1;
                    state_d     = StDone;
                end
            end

            StWr: begin
                wdog_d = wdog_q + 16'd1;
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_all && w_all) begin
`ifdef CPU_AXI_BRIDGE_WAIT_BRESP_EN
                    bready_d    = 1'b1;
                    state_d     = StWrResp;
`else
                    mem_ready_d = 1'b1;
                    state_d     = StDone;
`endif
                end else if (timeout) begin
                    awvalid_d   = 1'b0;
                    wvalid_d    = 1'b0;
                    bus_error_d = 1'b1;
                    mem_ready_d = 1'b1;
                    state_d     = StDone;
                end
            end

            StWrResp: begin
`ifdef CPU_AXI_BRIDGE_WAIT_BRESP_EN
                wdog_d = wdog_q + 16'd1;
                if (mem_axi_bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    mem_ready_d = 1'b1;
                    state_d     = StDone;
                end else if (timeout) begin
                    bready_d    = 1'b0;
                    bus_error_d = 1'b1;
                    mem_ready_d = 1'b1;
                    state_d     = StDone;
                end
`else
                state_d = StIdle;
`endif
            end

            // One-cycle bubble; mem_valid is ignored here so back-to-back requests are safe.
            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q     <= StIdle;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            araddr_q    <= 32'd0;
            arprot_q    <= 3'd0;
            awaddr_q    <= 32'd0;
            awprot_q    <= 3'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            rdata_q     <= 32'd0;
            mem_ready_q <= 1'b0;
            bus_error_q <= 1'b0;
            wdog_q      <= 16'd0;
`ifdef CPU_AXI_BRIDGE_WAIT_BRESP_EN
            bready_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            araddr_q    <= araddr_d;
            arprot_q    <= arprot_d;
            awaddr_q    <= awaddr_d;
            awprot_q    <= awprot_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            mem_ready_q <= mem_ready_d;
            bus_error_q <= bus_error_d;
            wdog_q      <= wdog_d;
`ifdef CPU_AXI_BRIDGE_WAIT_BRESP_EN
            bready_q    <= bready_d;
`endif
        end
    end

    assign mem_ready       = mem_ready_q;
    assign mem_rdata       = rdata_q;
    assign mem_axi_awvalid = awvalid_q;
    assign mem_axi_awaddr  = awaddr_q;
    assign mem_axi_awprot  = awprot_q;
    assign mem_axi_wvalid  = wvalid_q;
    assign mem_axi_wdata   = wdata_q;
    assign mem_axi_wstrb   = wstrb_q;
    assign mem_axi_arvalid = arvalid_q;
    assign mem_axi_araddr  = araddr_q;
    assign mem_axi_arprot  = arprot_q;
    assign mem_axi_rready  = rready_q;
    assign bus_error       = bus_error_q;
`ifdef CPU_AXI_BRIDGE_WAIT_BRESP_EN
    assign mem_axi_bready  = bready_q;
`else
    assign mem_axi_bready  = 1'b1;
`endif

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed self-checking bench for cpu_axi_bridge (default build, watchdog set to 16 cycles).
module tb_cpu_axi_bridge;

    logic        CLK;
    logic        RSTb;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic        bus_error;

    int errors = 0;
    int checks = 0;

    cpu_axi_bridge #(
        .TIMEOUT_CYCLES(16),
        .ERR_DATA      (32'hDEADBEEF)
    ) dut (
        .CLK            (CLK),
        .RSTb           (RSTb),
        .mem_valid      (mem_valid),
        .mem_instr      (mem_instr),
        .mem_ready      (mem_ready),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_rdata      (mem_rdata),
        .mem_axi_awvalid(awvalid),
        .mem_axi_awready(awready),
        .mem_axi_awaddr (awaddr),
        .mem_axi_awprot (awprot),
        .mem_axi_wvalid (wvalid),
        .mem_axi_wready (wready),
        .mem_axi_wdata  (wdata),
        .mem_axi_wstrb  (wstrb),
        .mem_axi_bvalid (bvalid),
        .mem_axi_bready (bready),
        .mem_axi_arvalid(arvalid),
        .mem_axi_arready(arready),
        .mem_axi_araddr (araddr),
        .mem_axi_arprot (arprot),
        .mem_axi_rvalid (rvalid),
        .mem_axi_rready (rready),
        .mem_axi_rdata  (rdata),
        .bus_error      (bus_error)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RSTb = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0;
        mem_wstrb = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0;
        rvalid = 1'b0; rdata = '0;
        #2 RSTb = 1'b0;
        #2;
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_mem_ready: got %b want 0", mem_ready); end
        checks++; if ({arvalid, awvalid, wvalid, rready} !== 4'b0000) begin errors++; $display("FAIL rst_valids: got %b want 0000", {arvalid, awvalid, wvalid, rready}); end
        checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL rst_bus_error: got %b want 0", bus_error); end
        checks++; if ({araddr, awaddr, wdata, mem_rdata} !== 128'd0) begin errors++; $display("FAIL rst_data: got %h want 0", {araddr, awaddr, wdata, mem_rdata}); end
        checks++; if ({arprot, awprot, wstrb} !== 10'd0) begin errors++; $display("FAIL rst_prot_strb: got %h want 0", {arprot, awprot, wstrb}); end
        tick; tick;
        RSTb = 1'b1;
        tick;
        checks++; if ({arvalid, awvalid, wvalid, rready, mem_ready} !== 5'b0) begin errors++; $display("FAIL rst_idle: got %b want 00000", {arvalid, awvalid, wvalid, rready, mem_ready}); end
        checks++; if (bready !== 1'b1) begin errors++; $display("FAIL rst_bready: got %b want 1", bready); end
    endtask

    task automatic test_read;
        mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h0000_0010; mem_wstrb = 4'h0;
        tick;
        checks++; if ({arvalid, rready, mem_ready} !== 3'b110) begin errors++; $display("FAIL rd_issue: got %b want 110", {arvalid, rready, mem_ready}); end
        checks++; if (araddr !== 32'h10) begin errors++; $display("FAIL rd_araddr: got %h want 00000010", araddr); end
        checks++; if (arprot !== 3'b000) begin errors++; $display("FAIL rd_arprot: got %b want 000", arprot); end
        arready = 1'b1;
        tick;
        arready = 1'b0;
        checks++; if ({arvalid, rready, mem_ready} !== 3'b010) begin errors++; $display("FAIL rd_ar_done: got %b want 010", {arvalid, rready, mem_ready}); end
        tick;
        checks++; if ({rready, mem_ready, araddr} !== {2'b10, 32'h10}) begin errors++; $display("FAIL rd_wait: got %b %b %h want 1 0 00000010", rready, mem_ready, araddr); end
        rvalid = 1'b1; rdata = 32'h1234_5678;
        tick;
        rvalid = 1'b0; mem_valid = 1'b0;
        checks++; if ({mem_ready, rready} !== 2'b10) begin errors++; $display("FAIL rd_complete: got %b want 10", {mem_ready, rready}); end
        checks++; if (mem_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got %h want 12345678", mem_rdata); end
        tick;
        checks++; if ({mem_ready, bus_error} !== 2'b00) begin errors++; $display("FAIL rd_pulse_end: got %b want 00", {mem_ready, bus_error}); end
        checks++; if (araddr !== 32'h10) begin errors++; $display("FAIL rd_hold: got %h want 00000010", araddr); end
    endtask

    task automatic test_write;
        mem_valid = 1'b1; mem_addr = 32'h1000_0004; mem_wdata = 32'hCAFE_F00D; mem_wstrb = 4'hF;
        tick;
        checks++; if ({awvalid, wvalid, mem_ready} !== 3'b110) begin errors++; $display("FAIL wr_issue: got %b want 110", {awvalid, wvalid, mem_ready}); end
        checks++; if ({awaddr, wdata, wstrb, awprot} !== {32'h1000_0004, 32'hCAFE_F00D, 4'hF, 3'b000}) begin errors++; $display("FAIL wr_fields: got %h %h %h %b", awaddr, wdata, wstrb, awprot); end
        awready = 1'b1;
        tick;
        awready = 1'b0;
        checks++; if ({awvalid, wvalid, mem_ready} !== 3'b010) begin errors++; $display("FAIL wr_aw_done: got %b want 010", {awvalid, wvalid, mem_ready}); end
        tick;
        checks++; if ({awvalid, wvalid, mem_ready} !== 3'b010) begin errors++; $display("FAIL wr_w_wait: got %b want 010", {awvalid, wvalid, mem_ready}); end
        wready = 1'b1;
        tick;
        wready = 1'b0; mem_valid = 1'b0;
        checks++; if ({awvalid, wvalid, mem_ready} !== 3'b001) begin errors++; $display("FAIL wr_complete: got %b want 001", {awvalid, wvalid, mem_ready}); end
        checks++; if ({awaddr, wdata} !== {32'h1000_0004, 32'hCAFE_F00D}) begin errors++; $display("FAIL wr_hold: got %h %h", awaddr, wdata); end
        tick;
        checks++; if ({awvalid, wvalid, mem_ready} !== 3'b000) begin errors++; $display("FAIL wr_pulse_end: got %b want 000", {awvalid, wvalid, mem_ready}); end
    endtask

    task automatic test_prot;
        mem_valid = 1'b1; mem_instr = 1'b1; mem_addr = 32'h0000_0200; mem_wstrb = 4'h0;
        tick;
        checks++; if (arprot !== 3'b100) begin errors++; $display("FAIL prot_ifetch: got %b want 100", arprot); end
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hA5A5_0001;
        tick;
        arready = 1'b0; rvalid = 1'b0; mem_valid = 1'b0;
        checks++; if ({mem_ready, arvalid, rready, mem_rdata} !== {3'b100, 32'hA5A5_0001}) begin errors++; $display("FAIL prot_same_cycle: got %b%b%b %h", mem_ready, arvalid, rready, mem_rdata); end
        tick; tick;
        mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h0000_0204;
        tick;
        checks++; if (arprot !== 3'b000) begin errors++; $display("FAIL prot_data: got %b want 000", arprot); end
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h0;
        tick;
        arready = 1'b0; rvalid = 1'b0; mem_valid = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        awready = 1'b1; wready = 1'b1;
        mem_valid = 1'b1; mem_addr = 32'h0000_0300; mem_wdata = 32'h1122_3344; mem_wstrb = 4'h3;
        tick;
        checks++; if ({awvalid, wvalid} !== 2'b11) begin errors++; $display("FAIL b2b_wr_issue: got %b want 11", {awvalid, wvalid}); end
        tick;
        awready = 1'b0; wready = 1'b0;
        checks++; if ({awvalid, wvalid, mem_ready} !== 3'b001) begin errors++; $display("FAIL b2b_wr_done: got %b want 001", {awvalid, wvalid, mem_ready}); end
        mem_addr = 32'h0000_0304; mem_wstrb = 4'h0;
        tick;
        checks++; if ({arvalid, awvalid, wvalid, mem_ready} !== 4'b0000) begin errors++; $display("FAIL b2b_bubble: got %b want 0000", {arvalid, awvalid, wvalid, mem_ready}); end
        tick;
        checks++; if ({arvalid, araddr} !== {1'b1, 32'h304}) begin errors++; $display("FAIL b2b_rd_issue: got %b %h want 1 00000304", arvalid, araddr); end
        checks++; if ({awaddr, wdata, wstrb} !== {32'h300, 32'h1122_3344, 4'h3}) begin errors++; $display("FAIL b2b_wr_hold: got %h %h %h", awaddr, wdata, wstrb); end
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h0000_0055;
        tick;
        arready = 1'b0; rvalid = 1'b0; mem_valid = 1'b0;
        checks++; if ({mem_ready, mem_rdata} !== {1'b1, 32'h55}) begin errors++; $display("FAIL b2b_rd_done: got %b %h want 1 00000055", mem_ready, mem_rdata); end
        tick;
        checks++; if ({arvalid, awvalid, wvalid, mem_ready} !== 4'b0000) begin errors++; $display("FAIL b2b_end: got %b want 0000", {arvalid, awvalid, wvalid, mem_ready}); end
    endtask

    task automatic test_timeout;
        int cycles;
        mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h0000_0040; mem_wstrb = 4'h0;
        tick;
        cycles = 0;
        arready = 1'b1;
        tick;
        cycles++;
        arready = 1'b0;
        while (mem_ready !== 1'b1 && cycles < 100) begin
            tick;
            cycles++;
        end
        mem_valid = 1'b0;
        checks++; if (cycles !== 16) begin errors++; $display("FAIL to_latency: got %0d want 16", cycles); end
        checks++; if (mem_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL to_rdata: got %h want deadbeef", mem_rdata); end
        checks++; if ({bus_error, arvalid, rready} !== 3'b100) begin errors++; $display("FAIL to_flags: got %b want 100", {bus_error, arvalid, rready}); end
        tick;
        mem_valid = 1'b1; mem_addr = 32'h0000_0044;
        tick;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h0BAD_F00D;
        tick;
        arready = 1'b0; rvalid = 1'b0; mem_valid = 1'b0;
        checks++; if ({mem_ready, mem_rdata} !== {1'b1, 32'h0BAD_F00D}) begin errors++; $display("FAIL to_good_read: got %b %h", mem_ready, mem_rdata); end
        checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", bus_error); end
        tick;
    endtask

    task automatic test_async_reset;
        int seen;
        mem_valid = 1'b1; mem_addr = 32'h0000_0500; mem_wstrb = 4'h0;
        tick;
        checks++; if ({arvalid, rready} !== 2'b11) begin errors++; $display("FAIL ar_pre: got %b want 11", {arvalid, rready}); end
        #2 RSTb = 1'b0;
        mem_valid = 1'b0;
        #1;
        checks++; if ({arvalid, rready, mem_ready, bus_error} !== 4'b0000) begin errors++; $display("FAIL ar_async: got %b want 0000", {arvalid, rready, mem_ready, bus_error}); end
        checks++; if (araddr !== 32'd0) begin errors++; $display("FAIL ar_addr_clr: got %h want 0", araddr); end
        tick;
        RSTb = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (mem_ready === 1'b1 || arvalid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL ar_no_ready: got %0d want 0", seen); end
        mem_valid = 1'b1; mem_addr = 32'h0000_0508;
        tick;
        checks++; if ({arvalid, araddr} !== {1'b1, 32'h508}) begin errors++; $display("FAIL ar_idle: got %b %h want 1 00000508", arvalid, araddr); end
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h1;
        tick;
        arready = 1'b0; rvalid = 1'b0; mem_valid = 1'b0;
        tick;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_prot();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
